modmul_seq_ctrl: RTL and testbench

- Sequencer for the bit-serial interleaved modular multiplier used in the ECC entity-authentication datapath. Computes result = (a*b) mod p.
- Latches operands on a start/ready handshake. Scans b MSB-first, one bit per clock, and drives the double/conditional-add/reduce step each cycle.
- Reports done/err. Replaces the ad-hoc load-pulse sequencing of the serial multiplier and lets the point-arithmetic layer issue one multiply at a time.

---
 rtl/modmul_seq_ctrl_if.sv | 28 ++
 rtl/modmul_seq_ctrl.sv | 100 ++++++++++
 tb/tb_modmul_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/modmul_seq_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial modular multiplier sequencer.
// The master issues start/abort and operands; the slave returns status and the product.
interface modmul_seq_ctrl_if #(
  parameter int W  = 4,
  parameter int CW = (W > 2) ? $clog2(W) : 1
);
  logic          start;
  logic          abort;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  p;
  logic          ready;
  logic          busy;
  logic [CW-1:0] bit_idx;
  logic          done;
  logic          err;
  logic [W-1:0]  result;

  modport master (
    output start, abort, a, b, p,
    input  ready, busy, bit_idx, done, err, result
  );

  modport slave (
    input  start, abort, a, b, p,
    output ready, busy, bit_idx, done, err, result
  );
endinterface

// File: rtl/modmul_seq_ctrl.sv
// Sequencer for the interleaved (double / conditional-add / reduce) modular multiplier.
// Scans the latched multiplier MSB-first, one bit per clock, yielding (a*b) mod p.
module modmul_seq_ctrl #(
  parameter int W  = 4,
  parameter int CW = (W > 2) ? $clog2(W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  modmul_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_q, b_q, p_q, acc, result_q;
  logic [CW-1:0] idx_q;
  logic          err_q;

  logic          operand_bad;
  logic          last_bit;
  logic [W:0]    dbl;
  logic [W-1:0]  dbl_red;
  logic [W:0]    sum;
  logic [W-1:0]  sum_red;

  // One step of the interleaved multiply; acc < p keeps both partials below 2p.
  always_comb begin
    operand_bad = (bus.p < W'(2)) || (bus.a >= bus.p);
    last_bit    = (idx_q == '0);
    dbl         = {acc, 1'b0};
    dbl_red     = (dbl >= {1'b0, p_q}) ? W'(dbl - {1'b0, p_q}) : dbl[W-1:0];
    sum         = {1'b0, dbl_red} + (b_q[idx_q] ? {1'b0, a_q} : '0);
    sum_red     = (sum >= {1'b0, p_q}) ? W'(sum - {1'b0, p_q}) : sum[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Abort wins over completion on the final RUN edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = operand_bad ? DONE : RUN;
      RUN: begin
        if (bus.abort)    state_next = IDLE;
        else if (last_bit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      acc      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            p_q <= bus.p;
            if (operand_bad) begin
              err_q    <= 1'b1;
              result_q <= '0;
            end else begin
              acc   <= '0;
              idx_q <= CW'(W - 1);
              err_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (!bus.abort) begin
            acc <= sum_red;
            if (last_bit) result_q <= sum_red;
            else          idx_q    <= idx_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.bit_idx = idx_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_modmul_seq_ctrl.sv
// Directed bench for modmul_seq_ctrl: W=4 and W=8 instances, hand-computed products mod p.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_modmul_seq_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  modmul_seq_ctrl_if #(.W(4)) bus4 ();
  modmul_seq_ctrl_if #(.W(8)) bus8 ();

  modmul_seq_ctrl #(.W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  modmul_seq_ctrl #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start for one edge; returns at the falling edge right after acceptance.
  task automatic applyStimulus(input logic [3:0] a_in, input logic [3:0] b_in, input logic [3:0] p_in);
    @(negedge clk);
    bus4.a     = a_in;
    bus4.b     = b_in;
    bus4.p     = p_in;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  // Follows the four RUN cycles and stops in the done cycle.
  task automatic expectRun(input string tag, input logic [3:0] exp_result);
    for (int i = 3; i >= 0; i--) begin
      checkOutput({tag, "_busy"}, bus4.busy, 1);
      checkOutput({tag, "_bit_idx"}, bus4.bit_idx, i);
      @(negedge clk);
    end
    checkOutput({tag, "_done"}, bus4.done, 1);
    checkOutput({tag, "_result"}, bus4.result, exp_result);
    checkOutput({tag, "_err"}, bus4.err, 0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    bus4.start = 0; bus4.abort = 0; bus4.a = 0; bus4.b = 0; bus4.p = 0;
    bus8.start = 0; bus8.abort = 0; bus8.a = 0; bus8.b = 0; bus8.p = 0;
    rst = 1'b1;
    #2;
    checkOutput("rst_ready", bus4.ready, 1);
    checkOutput("rst_busy", bus4.busy, 0);
    checkOutput("rst_done", bus4.done, 0);
    checkOutput("rst_err", bus4.err, 0);
    checkOutput("rst_result", bus4.result, 0);
    checkOutput("rst_bit_idx", bus4.bit_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // 7*11 = 77 = 5*13 + 12
    applyStimulus(4'd7, 4'd11, 4'd13);
    expectRun("mul_7_11", 4'd12);
    @(negedge clk);
    checkOutput("after_done_done", bus4.done, 0);
    checkOutput("after_done_ready", bus4.ready, 1);
    checkOutput("after_done_result", bus4.result, 12);

    // 12*15 = 180 = 13*13 + 11, then a restart requested during done
    applyStimulus(4'd12, 4'd15, 4'd13);
    expectRun("mul_12_15", 4'd11);
    bus4.b     = 4'd0;
    bus4.start = 1'b1;
    @(negedge clk);
    checkOutput("restart_wait_ready", bus4.ready, 1);
    checkOutput("restart_wait_busy", bus4.busy, 0);
    @(negedge clk);
    bus4.start = 1'b0;
    expectRun("mul_12_0", 4'd0);

    // Abort on the second RUN cycle: result 0 must survive
    applyStimulus(4'd7, 4'd11, 4'd13);
    @(negedge clk);
    checkOutput("abort_bit_idx", bus4.bit_idx, 2);
    bus4.abort = 1'b1;
    @(negedge clk);
    bus4.abort = 1'b0;
    checkOutput("abort_ready", bus4.ready, 1);
    checkOutput("abort_busy", bus4.busy, 0);
    checkOutput("abort_result", bus4.result, 0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus4.done) n++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", n, 0);

    // Operand check failures: a >= p, then p < 2
    applyStimulus(4'd13, 4'd5, 4'd13);
    checkOutput("a_ge_p_done", bus4.done, 1);
    checkOutput("a_ge_p_err", bus4.err, 1);
    checkOutput("a_ge_p_result", bus4.result, 0);
    checkOutput("a_ge_p_busy", bus4.busy, 0);
    @(negedge clk);
    checkOutput("a_ge_p_idle", bus4.ready, 1);
    checkOutput("a_ge_p_busy2", bus4.busy, 0);
    applyStimulus(4'd0, 4'd5, 4'd1);
    checkOutput("p_lt_2_done", bus4.done, 1);
    checkOutput("p_lt_2_err", bus4.err, 1);
    checkOutput("p_lt_2_busy", bus4.busy, 0);
    @(negedge clk);

    // New start and operands during RUN must not disturb the running multiply
    applyStimulus(4'd7, 4'd11, 4'd13);
    bus4.start = 1'b1;
    bus4.a = 4'd3; bus4.b = 4'd5; bus4.p = 4'd7;
    expectRun("ignore_start", 4'd12);
    bus4.start = 1'b0;
    @(negedge clk);

    // Abort coinciding with the last bit: no done, result 12 retained
    applyStimulus(4'd12, 4'd15, 4'd13);
    repeat (3) @(negedge clk);
    checkOutput("late_abort_bit_idx", bus4.bit_idx, 0);
    bus4.abort = 1'b1;
    @(negedge clk);
    bus4.abort = 1'b0;
    checkOutput("late_abort_done", bus4.done, 0);
    checkOutput("late_abort_ready", bus4.ready, 1);
    checkOutput("late_abort_result", bus4.result, 12);

    // Asynchronous reset between clock edges
    applyStimulus(4'd7, 4'd11, 4'd13);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_ready", bus4.ready, 1);
    checkOutput("async_rst_busy", bus4.busy, 0);
    checkOutput("async_rst_done", bus4.done, 0);
    checkOutput("async_rst_result", bus4.result, 0);
    checkOutput("async_rst_bit_idx", bus4.bit_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // W=8: 200*255 = 51000 = 203*251 + 47
    @(negedge clk);
    bus8.a = 8'd200; bus8.b = 8'd255; bus8.p = 8'd251;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    checkOutput("w8_bit_idx", bus8.bit_idx, 7);
    n = 0;
    while (!bus8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w8_latency", n, 8);
    checkOutput("w8_result", bus8.result, 47);
    checkOutput("w8_err", bus8.err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
